rr_mux_arbiter: RTL and testbench
=================================

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter: BURST, default 4, max transfers per grant; legal range 1..15.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  4  request from requesters 0..3, level, held until served or abandoned.
REQ-005 Port: d0, d1, d2, d3  input  4 each  requester data words.
REQ-006 Port: ready  input  1  consumer accepts the current word this cycle.
REQ-007 Port: gnt  output  4  one-hot grant, registered; 4'b0000 when idle.
REQ-008 Port: sel  output  2  mux select of the granted requester, registered.
REQ-009 Port: valid  output  1  granted word present on out.
REQ-010 Port: out  output  4  selected data word.

Function
REQ-011 The block SHALL have two states, IDLE and GRANT, plus a 2-bit round-robin pointer ptr and a 4-bit beat counter cnt.
REQ-012 IDLE, req==0 -> SHALL stay IDLE; gnt=0, cnt unchanged.
REQ-013 IDLE, req!=0 -> SHALL pick the first set req[i] scanning i=ptr, ptr+1, ... mod 4; next cycle state=GRANT, gnt=1<<i, sel=i, cnt=0.
REQ-014 Request-to-grant latency SHALL be exactly 1 cycle from an IDLE sample of req.
REQ-015 valid SHALL equal (state==GRANT) & req[sel], combinationally.
REQ-016 out SHALL equal the 4-bit word of input d[sel] when valid=1, else 4'b0000.
REQ-017 A transfer SHALL occur on a rising edge where valid & ready; each transfer increments cnt by 1.
REQ-018 In GRANT, release SHALL occur at the edge where req[sel]==0, or where a transfer makes cnt+1==BURST.
REQ-019 On release: next state=IDLE, gnt=0, ptr=sel+1 mod 4, cnt=0; sel holds its value.
REQ-020 Release priority: the BURST-limit and dropped-request conditions in the same cycle SHALL produce a single identical release.
REQ-021 GRANT without a transfer (ready=0, req[sel]=1) SHALL hold gnt, sel, cnt indefinitely; no timeout.
REQ-022 Changes on req of non-granted requesters SHALL have no effect during GRANT.
REQ-023 Every release SHALL insert exactly one IDLE cycle before the next grant; back-to-back grants SHALL be separated by 1 cycle with gnt=0.
REQ-024 ptr SHALL NOT change except on release, so a single persistent requester alternates GRANT(BURST beats)/IDLE(1 cycle).
REQ-025 gnt SHALL never have more than one bit set.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, gnt=0, sel=0, ptr=0, cnt=0, making valid=0 and out=0, independent of clk.
REQ-027 Reset asserted mid-GRANT SHALL abandon the burst with no further transfer; after deassertion arbitration restarts from ptr=0.
REQ-028 The first rising edge after rst deasserts SHALL be a normal IDLE arbitration edge.

Verification
REQ-029 Reset, then req=4'b0100, d2=4'hA, ready=1 -> next cycle gnt=4'b0100, sel=2, valid=1, out=4'hA; release after 4 transfers; ptr=3.
REQ-030 req=4'b1111 held, ready=1, BURST=4 -> grants in order 0,1,2,3,0; each 4 beats followed by one gnt=0 cycle.
REQ-031 Granted req[1], ready=0 for 10 cycles -> gnt=4'b0010, cnt=0, valid=1 held; then ready=1 -> 4 transfers, release.
REQ-032 Granted req[3] drops after 2 transfers -> same edge releases; valid=0, out=0; next grant starts scan at 0.
REQ-033 rst pulsed between clock edges during beat 2 of a grant to requester 2 -> gnt=0, valid=0, out=0 immediately; with req=4'b0100 still asserted, requester 2 regranted one edge after rst deasserts with cnt=0.
REQ-034 BURST=1, req=4'b0011, ready=1 -> one transfer per grant, alternating 0,1 with one idle cycle between grants.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin 4:1 arbiter with burst-limited data mux
// Grants one requester at a time for up to BURST accepted words, then rotates.
module rr_mux_arbiter #(
  parameter int BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic       ready,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic [3:0] out
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] cnt;
  logic       found;
  logic [1:0] pick;
  logic [1:0] cand;
  logic       xfer;
  logic       last;

  // First requesting index at or after ptr, wrapping mod 4.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    cand  = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign valid = (state == GRANT) && req[sel];
  assign xfer  = valid && ready;
  assign last  = xfer && ((cnt + 4'd1) == 4'(BURST));

  always_comb begin
    out = 4'b0000;
    if (valid) begin
      case (sel)
        2'd0:    out = d0;
        2'd1:    out = d1;
        2'd2:    out = d2;
        default: out = d3;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'd0;
      ptr   <= 2'd0;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= GRANT;
            gnt   <= 4'b0001 << pick;
            sel   <= pick;
            cnt   <= 4'd0;
          end
        end
        GRANT: begin
          // A dropped request and a final beat collapse into the same release.
          if (!req[sel] || last) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            ptr   <= sel + 2'd1;
            cnt   <= 4'd0;
          end else if (xfer) begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - scoreboard bench for rr_mux_arbiter
module tb_rr_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] d0, d1, d2, d3;
  logic       ready;
  logic [3:0] gnt, gnt1;
  logic [1:0] sel, sel1;
  logic       valid, valid1;
  logic [3:0] out, out1;

  int n_cmp = 0;
  int n_bad = 0;
  logic       mon_en = 1'b0;
  logic [3:0] prev_gnt = 4'b0000;
  logic [5:0] sbq[$];
  logic [7:0] q1[$];

  rr_mux_arbiter #(.BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .ready(ready), .gnt(gnt), .sel(sel), .valid(valid), .out(out)
  );

  rr_mux_arbiter #(.BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .ready(ready), .gnt(gnt1), .sel(sel1), .valid(valid1), .out(out1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req   = 4'b0000;
    ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic push_beats(input logic [1:0] idx, input logic [3:0] data, input int n);
    for (int i = 0; i < n; i++) sbq.push_back({idx, data});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
    check(tag, sbq.size(), 0);
    sbq.delete();
  endtask

  // Every accepted word is popped from the scoreboard the cycle it is offered.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      logic [5:0] e;
      check("gnt_onehot0", $onehot0(gnt), 1);
      if (gnt != 4'b0000 && prev_gnt != 4'b0000) check("idle_gap", gnt, prev_gnt);
      if (valid && ready) begin
        check("sb_has_entry", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          check("beat_sel", sel, e[5:4]);
          check("beat_out", out, e[3:0]);
          check("beat_gnt", gnt, 4'b0001 << e[5:4]);
        end
      end
      prev_gnt = gnt;
    end else begin
      prev_gnt = 4'b0000;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    d0 = 4'h3; d1 = 4'h6; d2 = 4'hA; d3 = 4'h5;
    rst = 1'b1; req = 4'b0000; ready = 1'b0;

    // reset state
    #2;
    check("rst_gnt", gnt, 4'b0000);
    check("rst_sel", sel, 2'd0);
    check("rst_valid", valid, 1'b0);
    check("rst_out", out, 4'h0);
    tick();
    rst = 1'b0;
    mon_en = 1'b1;

    // single requester 2, then ptr=3 steers 4'b1001 to requester 3
    req = 4'b0100; ready = 1'b1;
    push_beats(2'd2, 4'hA, 4);
    @(negedge clk);
    check("t1_latency_gnt", gnt, 4'b0000);
    @(negedge clk);
    check("t1_gnt", gnt, 4'b0100);
    check("t1_sel", sel, 2'd2);
    check("t1_valid", valid, 1'b1);
    check("t1_out", out, 4'hA);
    repeat (4) @(posedge clk);
    #1;
    req = 4'b1001;
    push_beats(2'd3, 4'h5, 4);
    @(negedge clk);
    check("t1_release_gnt", gnt, 4'b0000);
    repeat (5) @(posedge clk);
    #1;
    req = 4'b0000;
    drain("t1_drain");

    // all four requesting: 0,1,2,3,0
    do_reset();
    req = 4'b1111; ready = 1'b1;
    push_beats(2'd0, 4'h3, 4);
    push_beats(2'd1, 4'h6, 4);
    push_beats(2'd2, 4'hA, 4);
    push_beats(2'd3, 4'h5, 4);
    push_beats(2'd0, 4'h3, 4);
    repeat (25) @(posedge clk);
    #1;
    req = 4'b0000;
    drain("t2_drain");

    // stalled grant holds indefinitely
    do_reset();
    req = 4'b0010; ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_hold_gnt", gnt, 4'b0010);
      check("t3_hold_valid", valid, 1'b1);
    end
    check("t3_hold_cnt", dut.cnt, 4'd0);
    tick();
    push_beats(2'd1, 4'h6, 4);
    ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    req = 4'b0000;
    @(negedge clk);
    check("t3_release_gnt", gnt, 4'b0000);
    drain("t3_drain");

    // requester 3 drops after two beats; next scan starts at 0
    do_reset();
    req = 4'b1000; ready = 1'b1;
    push_beats(2'd3, 4'h5, 2);
    repeat (3) tick();
    req = 4'b0000;
    @(negedge clk);
    check("t4_drop_valid", valid, 1'b0);
    check("t4_drop_out", out, 4'h0);
    tick();
    req = 4'b1001;
    push_beats(2'd0, 4'h3, 4);
    @(negedge clk);
    check("t4_release_gnt", gnt, 4'b0000);
    repeat (5) tick();
    req = 4'b0000;
    drain("t4_drain");

    // asynchronous reset mid-burst, then immediate regrant
    do_reset();
    req = 4'b0100; ready = 1'b1;
    push_beats(2'd2, 4'hA, 1);
    tick();
    tick();
    #1 rst = 1'b1;
    #1;
    check("t5_rst_gnt", gnt, 4'b0000);
    check("t5_rst_valid", valid, 1'b0);
    check("t5_rst_out", out, 4'h0);
    #1 rst = 1'b0;
    push_beats(2'd2, 4'hA, 4);
    @(negedge clk);
    check("t5_after_rst_gnt", gnt, 4'b0000);
    tick();
    @(negedge clk);
    check("t5_regrant_gnt", gnt, 4'b0100);
    check("t5_regrant_cnt", dut.cnt, 4'd0);
    repeat (4) @(posedge clk);
    #1;
    req = 4'b0000;
    drain("t5_drain");

    // BURST=1 instance alternates 0,1 with one idle cycle between
    mon_en = 1'b0;
    do_reset();
    req = 4'b0011; ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      q1.push_back({4'b0000, 4'h0});
      q1.push_back({4'b0001, 4'h3});
      q1.push_back({4'b0000, 4'h0});
      q1.push_back({4'b0010, 4'h6});
    end
    while (q1.size() != 0) begin
      logic [7:0] e1;
      @(negedge clk);
      e1 = q1.pop_front();
      check("t6_gnt", gnt1, e1[7:4]);
      check("t6_out", out1, e1[3:0]);
    end
    req = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
